// File: rtl/cache_pkg.sv
// Shared cache definitions: FSM state encoding, default geometry and address-field helpers.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package cache_pkg;

    localparam int DEF_ADDR_W    = 10;
    localparam int DEF_NUM_SETS  = 4;
    localparam int DEF_BLK_WORDS = 4;
    localparam int DEF_IDX_W     = $clog2(DEF_NUM_SETS);
    localparam int DEF_OFF_W     = $clog2(DEF_BLK_WORDS);
    localparam int DEF_TAG_W     = DEF_ADDR_W - 2 - DEF_OFF_W - DEF_IDX_W;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COMPARE   = 3'd1,
        WRITEBACK = 3'd2,
        ALLOCATE  = 3'd3,
        RESPOND   = 3'd4
    } state_t;

    // Field extractors for the default geometry, for use by CPU-side integration logic
    function automatic logic [DEF_TAG_W-1:0] addr_tag(input logic [DEF_ADDR_W-1:0] addr);
        return addr[DEF_ADDR_W-1 -: DEF_TAG_W];
    endfunction

    function automatic logic [DEF_IDX_W-1:0] addr_index(input logic [DEF_ADDR_W-1:0] addr);
        return addr[2 + DEF_OFF_W +: DEF_IDX_W];
    endfunction

    function automatic logic [DEF_OFF_W-1:0] addr_offset(input logic [DEF_ADDR_W-1:0] addr);
        return addr[2 +: DEF_OFF_W];
    endfunction

endpackage

// File: rtl/cache_line_store.sv
// Line storage: per-set tag/valid/dirty plus data words; one write port, async read by index.
// Latency: reads are combinational, writes take effect on the next rising edge.
// Backpressure: none; every write presented is accepted.
module cache_line_store
    import cache_pkg::*;
#(
    parameter int NUM_SETS  = DEF_NUM_SETS,
    parameter int BLK_WORDS = DEF_BLK_WORDS,
    parameter int TAG_W     = DEF_TAG_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [$clog2(NUM_SETS)-1:0]   rd_idx,
    output logic                          rd_valid,
    output logic                          rd_dirty,
    output logic [TAG_W-1:0]              rd_tag,
    output logic [BLK_WORDS-1:0][31:0]    rd_line,
    input  logic [$clog2(NUM_SETS)-1:0]   wr_idx,
    input  logic                          wr_word,
    input  logic [$clog2(BLK_WORDS)-1:0]  wr_off,
    input  logic [31:0]                   wr_data,
    input  logic                          wr_meta,
    input  logic [TAG_W-1:0]              wr_tag,
    input  logic                          wr_valid,
    input  logic                          wr_dirty
);

    logic [NUM_SETS-1:0]         valid_q;
    logic [NUM_SETS-1:0]         dirty_q;
    logic [TAG_W-1:0]            tag_q  [NUM_SETS];
    logic [BLK_WORDS-1:0][31:0]  data_q [NUM_SETS];

    assign rd_valid = valid_q[rd_idx];
    assign rd_dirty = dirty_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_line  = data_q[rd_idx];

    // Status bits: cleared by reset so every line starts invalid and clean
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr_meta) begin
            valid_q[wr_idx] <= wr_valid;
            dirty_q[wr_idx] <= wr_dirty;
        end
    end

    // Tag and data arrays: never reset, contents are qualified by the valid bit
    always_ff @(posedge clk) begin
        if (wr_meta) begin
            tag_q[wr_idx] <= wr_tag;
        end
        if (wr_word) begin
            data_q[wr_idx][wr_off] <= wr_data;
        end
    end

endmodule

// File: rtl/dm_cache_controller.sv
// Direct-mapped write-back/write-allocate cache between CPU word accesses and main memory.
// Latency: hit completes 2 cycles after acceptance; a miss adds one request/done beat per word.
// Backpressure: CPU holds its request until cpu_done; each memory beat waits for mem_done.
module dm_cache_controller
    import cache_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int NUM_SETS  = DEF_NUM_SETS,
    parameter int BLK_WORDS = DEF_BLK_WORDS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_done,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_done
);

    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int OFF_W = $clog2(BLK_WORDS);
    localparam int TAG_W = ADDR_W - 2 - OFF_W - IDX_W;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(BLK_WORDS - 1);

    state_t                      state;
    logic [OFF_W-1:0]            beat;
    logic [ADDR_W-3:0]           req_word;
    logic [31:0]                 req_wdata;
    logic                        req_write;

    logic [TAG_W-1:0]            req_tag;
    logic [IDX_W-1:0]            req_idx;
    logic [OFF_W-1:0]            req_off;

    logic                        cur_valid;
    logic                        cur_dirty;
    logic [TAG_W-1:0]            cur_tag;
    logic [BLK_WORDS-1:0][31:0]  cur_line;
    logic                        hit;

    logic                        wr_word;
    logic [OFF_W-1:0]            wr_off;
    logic [31:0]                 wr_data;
    logic                        wr_meta;
    logic [TAG_W-1:0]            wr_tag;
    logic                        wr_valid;
    logic                        wr_dirty;

    // Byte offset is meaningless for word-only accesses
    logic unused_byte_off;
    assign unused_byte_off = ^cpu_addr[1:0];

    assign req_tag = req_word[ADDR_W-3 -: TAG_W];
    assign req_idx = req_word[OFF_W +: IDX_W];
    assign req_off = req_word[0 +: OFF_W];
    assign hit     = cur_valid && (cur_tag == req_tag);

    cache_line_store #(
        .NUM_SETS  (NUM_SETS),
        .BLK_WORDS (BLK_WORDS),
        .TAG_W     (TAG_W)
    ) u_store (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (req_idx),
        .rd_valid (cur_valid),
        .rd_dirty (cur_dirty),
        .rd_tag   (cur_tag),
        .rd_line  (cur_line),
        .wr_idx   (req_idx),
        .wr_word  (wr_word),
        .wr_off   (wr_off),
        .wr_data  (wr_data),
        .wr_meta  (wr_meta),
        .wr_tag   (wr_tag),
        .wr_valid (wr_valid),
        .wr_dirty (wr_dirty)
    );

    // Line-store writes: store hit, writeback completion, refill beats; suppressed during reset
    always_comb begin
        wr_word  = 1'b0;
        wr_off   = req_off;
        wr_data  = req_wdata;
        wr_meta  = 1'b0;
        wr_tag   = cur_tag;
        wr_valid = cur_valid;
        wr_dirty = cur_dirty;
        if (!reset) begin
            case (state)
                COMPARE: begin
                    if (hit && req_write) begin
                        wr_word  = 1'b1;
                        wr_meta  = 1'b1;
                        wr_dirty = 1'b1;
                    end
                end
                WRITEBACK: begin
                    if (mem_write && mem_done && (beat == LAST_BEAT)) begin
                        wr_meta  = 1'b1;
                        wr_dirty = 1'b0;
                    end
                end
                ALLOCATE: begin
                    if (mem_read && mem_done) begin
                        wr_word = 1'b1;
                        wr_off  = beat;
                        wr_data = mem_rdata;
                        if (beat == LAST_BEAT) begin
                            wr_meta  = 1'b1;
                            wr_tag   = req_tag;
                            wr_valid = 1'b1;
                            wr_dirty = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Controller FSM with registered CPU and memory outputs; one request per beat with a gap between
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            beat      <= '0;
            req_word  <= '0;
            req_wdata <= '0;
            req_write <= 1'b0;
            cpu_rdata <= '0;
            cpu_done  <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            cpu_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_read || cpu_write) begin
                        req_word  <= cpu_addr[ADDR_W-1:2];
                        req_wdata <= cpu_wdata;
                        req_write <= cpu_write;
                        state     <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (hit) begin
                        if (!req_write) begin
                            cpu_rdata <= cur_line[req_off];
                        end
                        cpu_done <= 1'b1;
                        state    <= RESPOND;
                    end else if (cur_valid && cur_dirty) begin
                        state <= WRITEBACK;
                    end else begin
                        state <= ALLOCATE;
                    end
                end
                WRITEBACK: begin
                    if (!mem_write) begin
                        mem_write <= 1'b1;
                        mem_addr  <= {cur_tag, req_idx, beat, 2'b00};
                        mem_wdata <= cur_line[beat];
                    end else if (mem_done) begin
                        mem_write <= 1'b0;
                        beat      <= beat + OFF_W'(1);
                        if (beat == LAST_BEAT) begin
                            state <= ALLOCATE;
                        end
                    end
                end
                ALLOCATE: begin
                    if (!mem_read) begin
                        mem_read <= 1'b1;
                        mem_addr <= {req_tag, req_idx, beat, 2'b00};
                    end else if (mem_done) begin
                        mem_read <= 1'b0;
                        beat     <= beat + OFF_W'(1);
                        if (beat == LAST_BEAT) begin
                            state <= COMPARE;
                        end
                    end
                end
                RESPOND: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_cache_controller.sv
// Bench for dm_cache_controller: access table, scoreboarded memory beats and CPU responses.
// Latency: memory model acknowledges one cycle after seeing a request.
// Backpressure: CPU request held until cpu_done, then dropped.
module tb_dm_cache_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_read, cpu_write;
    logic [9:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_done;
    logic        mem_read, mem_write;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;

    always #5 clk = ~clk;

    dm_cache_controller dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_read  (cpu_read),
        .cpu_write (cpu_write),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_done  (cpu_done),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done)
    );

    // Main memory model: done one cycle after a request, dropped after one cycle
    logic [31:0] mem    [256];
    logic [31:0] golden [256];

    always @(posedge clk) begin
        mem_done  <= (mem_read || mem_write) && !mem_done;
        mem_rdata <= mem[mem_addr[9:2]];
        if (mem_write && mem_done) mem[mem_addr[9:2]] <= mem_wdata;
    end

    typedef struct {
        bit          wr;
        logic [9:0]  addr;
        logic [31:0] data;
        bit          chk_data;
    } beat_t;

    typedef struct {
        bit          is_read;
        logic [31:0] data;
    } rsp_t;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [9:0]  addr;
        logic [31:0] wdata;
        int          wb_base;
        int          rf_base;
        logic [31:0] exp_rdata;
        bit          chk_lat;
    } vec_t;

    beat_t beat_q [$];
    rsp_t  rsp_q  [$];
    vec_t  vec    [16];

    int n_pass  = 0;
    int n_total = 0;
    int done_cnt = 0;
    int both_hi  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Monitors: CPU responses, memory beats, and mutual exclusion of mem_read/mem_write
    always @(negedge clk) begin
        if (mem_read && mem_write) both_hi++;
        if (cpu_done) begin
            done_cnt++;
            if (rsp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_cpu_done at %0t", $time);
            end else begin
                rsp_t r;
                r = rsp_q.pop_front();
                if (r.is_read) check("cpu_rdata", cpu_rdata, r.data);
            end
        end
        if ((mem_read || mem_write) && mem_done) begin
            if (beat_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_mem_beat rd=%0b wr=%0b addr=%h", mem_read, mem_write, mem_addr);
            end else begin
                beat_t b;
                b = beat_q.pop_front();
                check("beat_is_write", {31'b0, mem_write}, {31'b0, b.wr});
                check("beat_is_read", {31'b0, mem_read}, {31'b0, !b.wr});
                check("beat_addr", {22'b0, mem_addr}, {22'b0, b.addr});
                if (b.chk_data) check("beat_wdata", mem_wdata, b.data);
            end
        end
    end

    task automatic run_row(input vec_t v, input int i);
        int cyc;
        int d0;
        bit got;
        beat_t b;
        rsp_t  r;
        if (v.wb_base >= 0) begin
            for (int k = 0; k < 4; k++) begin
                b.wr = 1'b1; b.addr = 10'(v.wb_base + 4*k);
                b.data = golden[v.wb_base/4 + k]; b.chk_data = 1'b1;
                beat_q.push_back(b);
            end
        end
        if (v.rf_base >= 0) begin
            for (int k = 0; k < 4; k++) begin
                b.wr = 1'b0; b.addr = 10'(v.rf_base + 4*k);
                b.data = 32'h0; b.chk_data = 1'b0;
                beat_q.push_back(b);
            end
        end
        if (v.wr) golden[v.addr[9:2]] = v.wdata;
        r.is_read = !v.wr;
        r.data    = v.exp_rdata;
        rsp_q.push_back(r);
        d0 = done_cnt;
        cpu_read  = v.rd;
        cpu_write = v.wr;
        cpu_addr  = v.addr;
        cpu_wdata = v.wdata;
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 300) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            got = cpu_done;
        end
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        if (!got) begin
            n_total++;
            $display("FAIL row%0d_timeout: no cpu_done after %0d cycles", i, cyc);
            beat_q.delete();
            rsp_q.delete();
        end else if (v.chk_lat) begin
            check($sformatf("row%0d_hit_latency", i), 32'(cyc), 32'd2);
        end
        repeat (3) @(negedge clk);
        check($sformatf("row%0d_done_pulses", i), 32'(done_cnt - d0), 32'd1);
        check($sformatf("row%0d_beats_left", i), 32'(beat_q.size()), 32'd0);
        check($sformatf("row%0d_rsp_left", i), 32'(rsp_q.size()), 32'd0);
    endtask

    // Refill of 0x240 interrupted by reset while beat 2 is outstanding
    task automatic reset_mid_allocate();
        bit found;
        beat_t b;
        rsp_t  r;
        for (int k = 0; k < 4; k++) begin
            b.wr = 1'b0; b.addr = 10'(10'h240 + 4*k); b.data = 32'h0; b.chk_data = 1'b0;
            beat_q.push_back(b);
        end
        r.is_read = 1'b1;
        r.data    = 32'hA000_0240;
        rsp_q.push_back(r);
        cpu_read = 1'b1;
        cpu_addr = 10'h240;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            if (mem_read && mem_addr == 10'h248) found = 1'b1;
        end
        check("rst_reached_beat2", {31'b0, found}, 32'd1);
        reset    = 1'b1;
        cpu_read = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_mem_read", {31'b0, mem_read}, 32'd0);
        check("rst_mem_write", {31'b0, mem_write}, 32'd0);
        check("rst_cpu_done", {31'b0, cpu_done}, 32'd0);
        check("rst_mem_addr", {22'b0, mem_addr}, 32'd0);
        reset = 1'b0;
        check("rst_beats_done_before", 32'(beat_q.size()), 32'd2);
        beat_q.delete();
        rsp_q.delete();
        // Dirty store to 0x110 is lost by reset; memory still holds the original word
        golden[10'h110 >> 2] = 32'hA000_0110;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        for (int w = 0; w < 256; w++) mem[w] = 32'hA000_0000 | (w * 4);
        mem[10'h040 >> 2] = 32'h11;
        mem[10'h044 >> 2] = 32'h22;
        mem[10'h048 >> 2] = 32'h33;
        mem[10'h04C >> 2] = 32'h44;
        for (int w = 0; w < 256; w++) golden[w] = mem[w];

        //          rd wr addr    wdata          wb      rf      exp_rdata      lat
        vec[0]  = '{1, 0, 10'h040, 32'h0,         -1,     'h040,  32'h0000_0011, 0};
        vec[1]  = '{1, 0, 10'h048, 32'h0,         -1,     -1,     32'h0000_0033, 1};
        vec[2]  = '{0, 1, 10'h044, 32'hDEAD_BEEF, -1,     -1,     32'h0,         1};
        vec[3]  = '{1, 0, 10'h144, 32'h0,         'h040,  'h140,  32'hA000_0144, 0};
        vec[4]  = '{0, 1, 10'h3F0, 32'h0000_CAFE, -1,     'h3F0,  32'h0,         0};
        vec[5]  = '{1, 0, 10'h3FC, 32'h0,         -1,     -1,     32'hA000_03FC, 1};
        vec[6]  = '{1, 0, 10'h0F0, 32'h0,         'h3F0,  'h0F0,  32'hA000_00F0, 0};
        vec[7]  = '{1, 1, 10'h010, 32'h1234_5678, -1,     'h010,  32'h0,         0};
        vec[8]  = '{1, 0, 10'h010, 32'h0,         -1,     -1,     32'h1234_5678, 1};
        vec[9]  = '{1, 0, 10'h048, 32'h0,         -1,     'h040,  32'h0000_0033, 0};
        vec[10] = '{1, 0, 10'h044, 32'h0,         -1,     -1,     32'hDEAD_BEEF, 1};
        vec[11] = '{0, 1, 10'h110, 32'hBBBB_0000, 'h010,  'h110,  32'h0,         0};
        vec[12] = '{1, 0, 10'h240, 32'h0,         -1,     'h240,  32'hA000_0240, 0};
        vec[13] = '{1, 0, 10'h110, 32'h0,         -1,     'h110,  32'hA000_0110, 0};
        vec[14] = '{1, 0, 10'h3F0, 32'h0,         -1,     'h3F0,  32'h0000_CAFE, 0};
        vec[15] = '{1, 0, 10'h044, 32'h0,         -1,     'h040,  32'hDEAD_BEEF, 0};

        reset     = 1'b1;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_cpu_done", {31'b0, cpu_done}, 32'd0);
        check("reset_mem_read", {31'b0, mem_read}, 32'd0);
        check("reset_mem_write", {31'b0, mem_write}, 32'd0);
        check("reset_cpu_rdata", cpu_rdata, 32'd0);
        check("reset_mem_addr", {22'b0, mem_addr}, 32'd0);
        check("reset_mem_wdata", mem_wdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            if (i == 12) reset_mid_allocate();
            run_row(vec[i], i);
        end

        check("mem_holds_written_back_word", mem[10'h044 >> 2], 32'hDEAD_BEEF);
        check("mem_holds_evicted_store", mem[10'h3F0 >> 2], 32'h0000_CAFE);
        check("read_write_never_both", 32'(both_hi), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
